// File: rtl/ysyx_24110006_scoreboard.sv
// Decode-stage register scoreboard: per-register outstanding-write counters that stall decode
// on RAW hazards, WAW counter saturation and a full in-flight window.
module ysyx_24110006_scoreboard #(
  parameter int unsigned NR_REG       = 32,
  parameter int unsigned REG_W        = 5,
  parameter int unsigned NUM_REL      = 2,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter bit          BYPASS       = 1'b1,
  localparam int unsigned IF_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_valid,
  input  logic [6:0]               i_op,
  input  logic [REG_W-1:0]         i_rs1,
  input  logic [REG_W-1:0]         i_rs2,
  input  logic [REG_W-1:0]         i_rd,
  input  logic                     i_rd_wen,
  input  logic                     i_issue,
  input  logic [NUM_REL-1:0]       i_rel_valid,
  input  logic [NUM_REL*REG_W-1:0] i_rel_rd,
  input  logic                     i_flush,
  output logic                     o_stall,
  output logic [IF_W-1:0]          o_inflight,
  output logic                     o_err
);

  localparam int unsigned HIT_W = $clog2(NUM_REL + 1);
  localparam int unsigned CMP_W = ((CNT_W > HIT_W) ? CNT_W : HIT_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [CNT_W-1:0] r_pend [NR_REG];
  logic [IF_W-1:0]  r_inflight;
  logic             r_err;

  logic [HIT_W-1:0] w_hits   [NR_REG];
  logic [CMP_W-1:0] w_avail  [NR_REG];
  logic [CNT_W-1:0] w_pend_d [NR_REG];
  logic [NR_REG-1:0] w_busy;
  logic [HIT_W-1:0] w_dec;
  logic [IF_W-1:0]  w_inflight_d;
  logic w_use_rs1, w_use_rs2, w_wr, w_raw, w_sat, w_full, w_stall, w_fire, w_underflow;

  // Per-register release hit count; index 0 never matches.
  always_comb begin
    for (int r = 0; r < NR_REG; r++) begin
      w_hits[r] = '0;
      for (int k = 0; k < NUM_REL; k++) begin
        if (r != 0 && i_rel_valid[k] && i_rel_rd[k*REG_W +: REG_W] == REG_W'(r)) begin
          w_hits[r] = w_hits[r] + HIT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NR_REG; r++) begin
      if (BYPASS) begin
        w_busy[r] = CMP_W'(r_pend[r]) > CMP_W'(w_hits[r]);
      end else begin
        w_busy[r] = r_pend[r] != '0;
      end
    end
  end

  always_comb begin
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    case (i_op)
      OP_JALR, OP_IMM, OP_LOAD, OP_SYSTEM: w_use_rs1 = 1'b1;
      OP_BRANCH, OP_STORE, OP_REG: begin
        w_use_rs1 = 1'b1;
        w_use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_wr    = i_rd_wen && (i_rd != '0);
    w_raw   = (w_use_rs1 && w_busy[i_rs1]) || (w_use_rs2 && w_busy[i_rs2]);
    w_sat   = w_wr && (r_pend[i_rd] == CNT_MAX);
    w_full  = w_wr && (r_inflight == IF_W'(MAX_INFLIGHT));
    w_stall = i_valid && (w_raw || w_sat || w_full);
    w_fire  = i_valid && i_issue && !w_stall && w_wr;
  end

  // Releases beyond what is pending clamp at zero and are not counted against the window.
  always_comb begin
    w_dec       = '0;
    w_underflow = 1'b0;
    for (int r = 0; r < NR_REG; r++) begin
      w_avail[r] = CMP_W'(r_pend[r]) + CMP_W'(w_fire && (i_rd == REG_W'(r)));
      if (w_avail[r] >= CMP_W'(w_hits[r])) begin
        w_pend_d[r] = CNT_W'(w_avail[r] - CMP_W'(w_hits[r]));
        w_dec       = w_dec + w_hits[r];
      end else begin
        w_pend_d[r] = '0;
        w_dec       = w_dec + HIT_W'(w_avail[r]);
        w_underflow = 1'b1;
      end
      if (r == 0) begin
        w_pend_d[r] = '0;
      end
    end
    w_inflight_d = r_inflight + IF_W'(w_fire) - IF_W'(w_dec);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int r = 0; r < NR_REG; r++) begin
        r_pend[r] <= '0;
      end
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else if (i_flush) begin
      for (int r = 0; r < NR_REG; r++) begin
        r_pend[r] <= '0;
      end
      r_inflight <= '0;
    end else begin
      for (int r = 0; r < NR_REG; r++) begin
        r_pend[r] <= w_pend_d[r];
      end
      r_inflight <= w_inflight_d;
      if (w_underflow) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_stall    = w_stall;
  assign o_inflight = r_inflight;
  assign o_err      = r_err;

endmodule

// File: tb/tb_ysyx_24110006_scoreboard.sv
// Bench for the scoreboard: one BYPASS=1 and one BYPASS=0 instance share stimulus; a
// queue-based scoreboard checks both against a count-per-register reference model.
module tb_ysyx_24110006_scoreboard;

  localparam int NR = 32;

  localparam bit [6:0] OP_I     = 7'b0010011;
  localparam bit [6:0] OP_R     = 7'b0110011;
  localparam bit [6:0] OP_S     = 7'b0100011;
  localparam bit [6:0] OP_B     = 7'b1100011;
  localparam bit [6:0] OP_L     = 7'b0000011;
  localparam bit [6:0] OP_JALR  = 7'b1100111;
  localparam bit [6:0] OP_CSR   = 7'b1110011;
  localparam bit [6:0] OP_LUI   = 7'b0110111;
  localparam bit [6:0] OP_AUIPC = 7'b0010111;
  localparam bit [6:0] OP_JAL   = 7'b1101111;
  localparam bit [6:0] OP_FENCE = 7'b0001111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid, rd_wen, issue, flush;
  logic [6:0] op;
  logic [4:0] rs1, rs2, rd;
  logic [1:0] rel_v;
  logic [9:0] rel_rd;
  logic       stall1, stall0, err1, err0;
  logic [2:0] infl1, infl0;

  always #5 clk = ~clk;

  ysyx_24110006_scoreboard #(.BYPASS(1'b1)) u_dut_b1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid), .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
    .i_rd(rd), .i_rd_wen(rd_wen), .i_issue(issue), .i_rel_valid(rel_v), .i_rel_rd(rel_rd),
    .i_flush(flush), .o_stall(stall1), .o_inflight(infl1), .o_err(err1)
  );

  ysyx_24110006_scoreboard #(.BYPASS(1'b0)) u_dut_b0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid), .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
    .i_rd(rd), .i_rd_wen(rd_wen), .i_issue(issue), .i_rel_valid(rel_v), .i_rel_rd(rel_rd),
    .i_flush(flush), .o_stall(stall0), .o_inflight(infl0), .o_err(err0)
  );

  typedef struct {
    bit s1; bit s0; int i1; int i0; bit e1; bit e0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state, index 1 = bypass instance, index 0 = no-bypass instance.
  int m_pend [2][NR];
  int m_infl [2];
  bit m_err  [2];

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < NR; r++) m_pend[b][r] = 0;
      m_infl[b] = 0;
      m_err[b]  = 1'b0;
    end
  endfunction

  function automatic bit uses_rs1(logic [6:0] o);
    return o inside {OP_JALR, OP_I, OP_L, OP_CSR, OP_B, OP_S, OP_R};
  endfunction

  function automatic bit uses_rs2(logic [6:0] o);
    return o inside {OP_B, OP_S, OP_R};
  endfunction

  function automatic int hits_of(int r);
    int n = 0;
    if (r == 0) return 0;
    for (int k = 0; k < 2; k++) begin
      if (rel_v[k] && int'(rel_rd[k*5 +: 5]) == r) n++;
    end
    return n;
  endfunction

  function automatic int eff(int b, int r);
    int p;
    if (r == 0) return 0;
    p = m_pend[b][r] - ((b == 1) ? hits_of(r) : 0);
    return (p < 0) ? 0 : p;
  endfunction

  function automatic bit model_stall(int b);
    bit wr, raw, sat, full;
    wr   = rd_wen && (rd != 5'd0);
    raw  = (uses_rs1(op) && eff(b, int'(rs1)) > 0) || (uses_rs2(op) && eff(b, int'(rs2)) > 0);
    sat  = wr && (m_pend[b][rd] == 3);
    full = wr && (m_infl[b] == 4);
    return valid && (raw || sat || full);
  endfunction

  function automatic void model_update(int b);
    bit st;
    int r;
    st = model_stall(b);
    if (flush) begin
      for (int i = 0; i < NR; i++) m_pend[b][i] = 0;
      m_infl[b] = 0;
      return;
    end
    if (valid && issue && !st && rd_wen && rd != 5'd0) begin
      m_pend[b][rd]++;
      m_infl[b]++;
    end
    for (int k = 0; k < 2; k++) begin
      r = int'(rel_rd[k*5 +: 5]);
      if (rel_v[k] && r != 0) begin
        if (m_pend[b][r] > 0) begin
          m_pend[b][r]--;
          m_infl[b]--;
        end else begin
          m_err[b] = 1'b1;
        end
      end
    end
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.s1 = model_stall(1);
    e.s0 = model_stall(0);
    e.i1 = m_infl[1];
    e.i0 = m_infl[0];
    e.e1 = m_err[1];
    e.e0 = m_err[0];
    exp_q.push_back(e);
  endfunction

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endfunction

  // Monitor: sample outputs mid-cycle and compare with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall_b1", int'(stall1), int'(e.s1));
      chk("stall_b0", int'(stall0), int'(e.s0));
      chk("inflight_b1", int'(infl1), e.i1);
      chk("inflight_b0", int'(infl0), e.i0);
      chk("err_b1", int'(err1), int'(e.e1));
      chk("err_b0", int'(err0), int'(e.e0));
    end
  end

  task automatic cyc(bit v, bit [6:0] o, bit [4:0] s1, bit [4:0] s2, bit [4:0] d, bit w,
                     bit is, bit [1:0] rv, bit [4:0] r0, bit [4:0] r1, bit fl);
    valid = v; op = o; rs1 = s1; rs2 = s2; rd = d; rd_wen = w; issue = is;
    rel_v = rv; rel_rd = {r1, r0}; flush = fl;
    push_exp();
    @(posedge clk);
    model_update(1);
    model_update(0);
    #1;
  endtask

  function automatic bit [4:0] pick_rel();
    int r;
    for (int t = 0; t < 8; t++) begin
      r = $urandom_range(1, 7);
      if (m_pend[1][r] > 0 || m_pend[0][r] > 0) return 5'(r);
    end
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic rand_cyc();
    bit [6:0] ops [11] = '{OP_I, OP_R, OP_S, OP_B, OP_L, OP_JALR, OP_CSR, OP_LUI, OP_AUIPC,
                           OP_JAL, OP_FENCE};
    bit [6:0] o;
    bit [1:0] rv;
    o = ($urandom_range(0, 11) == 11) ? 7'($urandom) : ops[$urandom_range(0, 10)];
    rv[0] = ($urandom_range(0, 9) < 4);
    rv[1] = ($urandom_range(0, 9) < 3);
    cyc(($urandom_range(0, 9) < 8), o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
        5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 8),
        rv, pick_rel(), pick_rel(), ($urandom_range(0, 199) == 0));
  endtask

  task automatic idle_inputs();
    valid = 0; op = 7'd0; rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; rd_wen = 0; issue = 0;
    rel_v = 2'b00; rel_rd = 10'd0; flush = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state and basic RAW with release bypass difference.
    cyc(0, OP_I, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 5, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_R, 5, 0, 6, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_R, 5, 0, 6, 1, 1, 2'b01, 5, 0, 0);
    cyc(1, OP_R, 5, 0, 6, 1, 0, 2'b00, 0, 0, 0);
    cyc(0, OP_I, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);

    // WAW saturation on rd=7.
    repeat (3) cyc(1, OP_I, 0, 0, 7, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 7, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 7, 1, 1, 2'b01, 7, 0, 0);
    cyc(1, OP_I, 0, 0, 7, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 7, 1, 0, 2'b00, 0, 0, 0);
    cyc(0, OP_I, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);

    // Full in-flight window.
    for (int i = 1; i <= 4; i++) cyc(1, OP_I, 0, 0, 5'(i), 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 9, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_S, 10, 11, 0, 0, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 9, 1, 1, 2'b11, 1, 2, 0);
    cyc(0, OP_I, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);

    // Dual release of one register, then underflow.
    cyc(1, OP_I, 0, 0, 3, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 3, 1, 1, 2'b00, 0, 0, 0);
    cyc(0, OP_I, 0, 0, 0, 0, 0, 2'b11, 3, 3, 0);
    cyc(0, OP_I, 0, 0, 0, 0, 0, 2'b01, 3, 0, 0);
    cyc(0, OP_I, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

    // Source-less opcodes, rd=0 and rs=0.
    cyc(1, OP_I, 0, 0, 8, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_LUI, 8, 8, 12, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_AUIPC, 8, 8, 0, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_JAL, 8, 12, 0, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 0, 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_R, 8, 0, 0, 0, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_R, 0, 0, 13, 1, 1, 2'b11, 0, 8, 0);
    cyc(1, OP_B, 0, 12, 0, 0, 1, 2'b00, 0, 0, 0);

    // Flush racing a fire at inflight 3.
    cyc(0, OP_I, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
    for (int i = 1; i <= 3; i++) cyc(1, OP_I, 0, 0, 5'(i), 1, 1, 2'b00, 0, 0, 0);
    cyc(1, OP_I, 0, 0, 4, 1, 1, 2'b00, 0, 0, 1);
    cyc(1, OP_R, 1, 2, 0, 0, 1, 2'b00, 0, 0, 0);

    repeat (3000) rand_cyc();

    // Asynchronous reset mid-cycle, observed before any clock edge.
    for (int i = 1; i <= 2; i++) cyc(1, OP_I, 0, 0, 5'(i + 20), 1, 1, 2'b00, 0, 0, 0);
    idle_inputs();
    model_reset();
    push_exp();
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    repeat (300) rand_cyc();
    idle_inputs();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
